mx_writeback_queue: RTL and testbench

Collects completed results from the multi-cycle execute pipeline (stage 5 outputs) and presents them to the shared register-file write port. The single-cycle pipeline has priority on that port, so this block buffers results in a FIFO and drains them into free write slots. It also packs per-lane compare bits into a scalar mask. It raises an issue-stall signal early enough that ops already in flight in the multi-cycle pipeline can never overflow the FIFO.

---
 rtl/mx_writeback_queue_if.sv | 51 +++++
 rtl/mx_writeback_queue.sv | 123 ++++++++++++
 tb/tb_mx_writeback_queue.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mx_writeback_queue_if.sv
// Bundle between the multi-cycle pipeline stage 5, the writeback queue and the register-file write port.
// Widths here must match the localparams inside mx_writeback_queue.
interface mx_writeback_queue_if #(
  parameter int DEPTH = 8
);
  localparam int VECTOR_LANES = 16;
  localparam int THREAD_W     = 2;
  localparam int SUBCYCLE_W   = 4;

  typedef logic [THREAD_W-1:0]                thread_idx_t;
  typedef logic [SUBCYCLE_W-1:0]              subcycle_t;
  typedef logic [VECTOR_LANES-1:0][31:0]      vector_t;
  typedef struct packed {
    logic       has_dest;
    logic [4:0] dest_reg;
    logic       dest_is_vector;
    logic       is_compare;
  } decoded_instruction_t;

  logic                      mx5_instruction_valid;
  decoded_instruction_t      mx5_instruction;
  logic [VECTOR_LANES-1:0]   mx5_mask_value;
  thread_idx_t               mx5_thread_idx;
  subcycle_t                 mx5_subcycle;
  vector_t                   mx5_result;
  logic                      sx_wb_pending;

  logic                      mx_wb_en;
  thread_idx_t               mx_wb_thread_idx;
  logic [4:0]                mx_wb_dest_reg;
  logic                      mx_wb_is_vector;
  logic [VECTOR_LANES-1:0]   mx_wb_mask;
  vector_t                   mx_wb_value;
  subcycle_t                 mx_wb_subcycle;
  logic                      mx_stall_issue;
  logic [$clog2(DEPTH):0]    mx_queue_count;

  modport master (
    output mx5_instruction_valid, mx5_instruction, mx5_mask_value, mx5_thread_idx,
           mx5_subcycle, mx5_result, sx_wb_pending,
    input  mx_wb_en, mx_wb_thread_idx, mx_wb_dest_reg, mx_wb_is_vector, mx_wb_mask,
           mx_wb_value, mx_wb_subcycle, mx_stall_issue, mx_queue_count
  );

  modport slave (
    input  mx5_instruction_valid, mx5_instruction, mx5_mask_value, mx5_thread_idx,
           mx5_subcycle, mx5_result, sx_wb_pending,
    output mx_wb_en, mx_wb_thread_idx, mx_wb_dest_reg, mx_wb_is_vector, mx_wb_mask,
           mx_wb_value, mx_wb_subcycle, mx_stall_issue, mx_queue_count
  );
endinterface

// File: rtl/mx_writeback_queue.sv
// Buffers multi-cycle pipeline results and drains them into write-port slots the single-cycle pipeline leaves free.
// Optional MX_WRITEBACK_BYPASS_EN lets a result skip the empty FIFO straight into the write registers.
module mx_writeback_queue #(
  parameter int DEPTH      = 8,
  parameter int PIPE_DEPTH = 5
) (
  input  logic               clk,
  input  logic               reset,
  mx_writeback_queue_if.slave bus
);
  localparam int VECTOR_LANES = 16;
  localparam int THREAD_W     = 2;
  localparam int SUBCYCLE_W   = 4;
  localparam int AW           = $clog2(DEPTH);
  localparam int CW           = AW + 1;

  typedef struct packed {
    logic [THREAD_W-1:0]           thread_idx;
    logic [4:0]                    dest_reg;
    logic                          is_vector;
    logic [VECTOR_LANES-1:0]       mask;
    logic [VECTOR_LANES-1:0][31:0] value;
    logic [SUBCYCLE_W-1:0]         subcycle;
  } wb_entry_t;

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  wb_entry_t         out_q, out_d;
  wb_entry_t         in_entry;
  logic              en_q, en_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              accept, empty, full, pop, push, bypass, overflow;

  // Compare results collapse to one bit per lane in a scalar; scalar writes carry only lane 0.
  always_comb begin
    in_entry            = '0;
    in_entry.thread_idx = bus.mx5_thread_idx;
    in_entry.dest_reg   = bus.mx5_instruction.dest_reg;
    in_entry.mask       = bus.mx5_mask_value;
    in_entry.subcycle   = bus.mx5_subcycle;
    if (bus.mx5_instruction.is_compare) begin
      for (int i = 0; i < VECTOR_LANES; i++) begin
        in_entry.value[0][i] = bus.mx5_result[i][0];
      end
    end else if (bus.mx5_instruction.dest_is_vector) begin
      in_entry.is_vector = 1'b1;
      in_entry.value     = bus.mx5_result;
    end else begin
      in_entry.value[0]  = bus.mx5_result[0];
    end
  end

  assign accept = bus.mx5_instruction_valid && bus.mx5_instruction.has_dest;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign pop    = !bus.sx_wb_pending && !empty;
`ifdef MX_WRITEBACK_BYPASS_EN
  assign bypass = empty && accept && !bus.sx_wb_pending;
`else
  assign bypass = 1'b0;
`endif
  assign push     = accept && !bypass && (!full || pop);
  assign overflow = accept && !bypass && full && !pop;

  always_comb begin
    mem_d    = mem_q;
    out_d    = out_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    en_d     = pop || bypass;
    if (pop) begin
      out_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else if (bypass) begin
      out_d    = in_entry;
    end
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      out_q    <= '0;
      en_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      out_q    <= out_d;
      en_q     <= en_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.mx_wb_en         = en_q;
  assign bus.mx_wb_thread_idx = out_q.thread_idx;
  assign bus.mx_wb_dest_reg   = out_q.dest_reg;
  assign bus.mx_wb_is_vector  = out_q.is_vector;
  assign bus.mx_wb_mask       = out_q.mask;
  assign bus.mx_wb_value      = out_q.value;
  assign bus.mx_wb_subcycle   = out_q.subcycle;
  assign bus.mx_queue_count   = count_q;
  assign bus.mx_stall_issue   = (count_q >= CW'(DEPTH - PIPE_DEPTH));

  // Issue stall should make this unreachable; if it happens the entry is dropped and state is untouched.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !overflow);
endmodule

// File: tb/tb_mx_writeback_queue.sv
// Self-checking bench for mx_writeback_queue: directed table, corner sequences and random traffic
// compared against a queue-based reference model.
module tb_mx_writeback_queue;
  localparam int DEPTH      = 8;
  localparam int PIPE_DEPTH = 5;
  localparam int LANES      = 16;
`ifdef MX_WRITEBACK_BYPASS_EN
  localparam int EXP_LAT = 1;
  localparam bit BYPASS  = 1'b1;
`else
  localparam int EXP_LAT = 2;
  localparam bit BYPASS  = 1'b0;
`endif

  typedef logic [LANES-1:0][31:0] vec_t;

  typedef struct {
    logic [1:0]       thread;
    logic [4:0]       dest;
    logic             is_vector;
    logic [LANES-1:0] mask;
    vec_t             value;
    logic [3:0]       subcycle;
  } ent_t;

  typedef struct {
    logic             is_cmp;
    logic             is_vec;
    logic [4:0]       dest;
    logic [1:0]       thread;
    logic [31:0]      lane0;
    logic [LANES-1:0] lane_bits;
    logic [31:0]      exp_val;
    logic             exp_vec;
  } table_rec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mx_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

  mx_writeback_queue #(.DEPTH(DEPTH), .PIPE_DEPTH(PIPE_DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  ent_t       exp_q[$];
  ent_t       exp_out;
  logic       exp_en;
  table_rec_t tbl[5];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = $urandom();
    return v;
  endfunction

  // What the spec says should be written for the input currently on the bus.
  function automatic ent_t expected_entry();
    ent_t        e;
    logic [31:0] acc;
    e.thread    = bus.mx5_thread_idx;
    e.dest      = bus.mx5_instruction.dest_reg;
    e.mask      = bus.mx5_mask_value;
    e.subcycle  = bus.mx5_subcycle;
    e.value     = '0;
    e.is_vector = 1'b0;
    if (bus.mx5_instruction.is_compare) begin
      acc = 32'd0;
      for (int i = 0; i < LANES; i++) begin
        if (bus.mx5_result[i][0]) acc = acc + (32'd1 << i);
      end
      e.value[0] = acc;
    end else if (bus.mx5_instruction.dest_is_vector) begin
      e.value     = bus.mx5_result;
      e.is_vector = 1'b1;
    end else begin
      e.value[0]  = bus.mx5_result[0];
    end
    return e;
  endfunction

  task automatic model_edge();
    bit   accept;
    bit   byp;
    ent_t e;
    if (reset) begin
      exp_q.delete();
      exp_en  = 1'b0;
      exp_out = '{default: '0};
      return;
    end
    accept = bus.mx5_instruction_valid && bus.mx5_instruction.has_dest;
    byp    = BYPASS && exp_q.size() == 0 && accept && !bus.sx_wb_pending;
    e      = expected_entry();
    exp_en = 1'b0;
    if (!bus.sx_wb_pending && exp_q.size() > 0) begin
      exp_out = exp_q.pop_front();
      exp_en  = 1'b1;
    end else if (byp) begin
      exp_out = e;
      exp_en  = 1'b1;
    end
    if (accept && !byp && exp_q.size() < DEPTH) exp_q.push_back(e);
  endtask

  task automatic check_output();
    check("wb_en", bus.mx_wb_en, exp_en);
    check("wb_thread", bus.mx_wb_thread_idx, exp_out.thread);
    check("wb_dest", bus.mx_wb_dest_reg, exp_out.dest);
    check("wb_is_vector", bus.mx_wb_is_vector, exp_out.is_vector);
    check("wb_mask", bus.mx_wb_mask, exp_out.mask);
    check("wb_value", bus.mx_wb_value, exp_out.value);
    check("wb_subcycle", bus.mx_wb_subcycle, exp_out.subcycle);
    check("count", bus.mx_queue_count, exp_q.size());
    check("stall", bus.mx_stall_issue, exp_q.size() >= DEPTH - PIPE_DEPTH);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_output();
  endtask

  task automatic apply_stimulus(input logic valid, input logic has_dest, input logic is_cmp,
                                input logic is_vec, input logic [4:0] dest, input logic [1:0] thread,
                                input logic [LANES-1:0] mask, input vec_t result,
                                input logic [3:0] sub, input logic sx);
    bus.mx5_instruction_valid          = valid;
    bus.mx5_instruction.has_dest       = has_dest;
    bus.mx5_instruction.is_compare     = is_cmp;
    bus.mx5_instruction.dest_is_vector = is_vec;
    bus.mx5_instruction.dest_reg       = dest;
    bus.mx5_thread_idx                 = thread;
    bus.mx5_mask_value                 = mask;
    bus.mx5_result                     = result;
    bus.mx5_subcycle                   = sub;
    bus.sx_wb_pending                  = sx;
  endtask

  task automatic idle(input logic sx);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, '0, '0, 4'd0, sx);
  endtask

  task automatic push_random(input logic has_dest, input logic sx);
    apply_stimulus(1'b1, has_dest, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   5'($urandom()), 2'($urandom()), 16'($urandom()), rand_vec(), 4'($urandom()), sx);
  endtask

  initial begin
    int               lat;
    vec_t             r;
    vec_t             expv;
    logic [LANES-1:0] lb;
    logic [LANES-1:0] masks[4];
    bit               sx;
    bit               v;

    tbl[0] = '{1'b0, 1'b0, 5'd3,  2'd2, 32'h3f80_0000, 16'h0000, 32'h3f80_0000, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 5'd7,  2'd0, 32'h0,         16'h8021, 32'h0000_8021, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 5'd0,  2'd1, 32'h0,         16'hffff, 32'h0000_ffff, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 5'd12, 2'd3, 32'h0,         16'h0000, 32'h0000_0000, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 5'd31, 2'd3, 32'hdead_beef, 16'h1234, 32'hdead_beef, 1'b0};

    exp_q.delete();
    exp_en  = 1'b0;
    exp_out = '{default: '0};
    reset   = 1'b1;
    idle(1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Directed packing/latency table.
    for (int t = 0; t < 5; t++) begin
      idle(1'b0);
      tick();
      r  = rand_vec();
      lb = tbl[t].lane_bits;
      for (int i = 0; i < LANES; i++) r[i] = (r[i] & 32'hffff_fffe) | 32'(lb[i]);
      if (!tbl[t].is_cmp) r[0] = tbl[t].lane0;
      apply_stimulus(1'b1, 1'b1, tbl[t].is_cmp, tbl[t].is_vec, tbl[t].dest, tbl[t].thread,
                     16'hffff, r, 4'(t), 1'b0);
      tick();
      lat = 1;
      idle(1'b0);
      while (bus.mx_wb_en !== 1'b1 && lat < 5) begin
        tick();
        lat++;
      end
      expv    = '0;
      expv[0] = tbl[t].exp_val;
      check("tbl_latency", lat, EXP_LAT);
      check("tbl_dest", bus.mx_wb_dest_reg, tbl[t].dest);
      check("tbl_thread", bus.mx_wb_thread_idx, tbl[t].thread);
      check("tbl_is_vector", bus.mx_wb_is_vector, tbl[t].exp_vec);
      check("tbl_value", bus.mx_wb_value, expv);
      tick();
      check("tbl_single_pulse", bus.mx_wb_en, 1'b0);
    end

    // Write port held by the single-cycle pipeline while 4 vector results arrive.
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        masks[c] = 16'($urandom());
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'(c + 1), 2'(c), masks[c], rand_vec(), 4'(c), 1'b1);
      end else begin
        idle(1'b1);
      end
      tick();
      check("held_no_write", bus.mx_wb_en, 1'b0);
    end
    check("held_count", bus.mx_queue_count, 4);
    check("held_stall", bus.mx_stall_issue, 1'b1);
    idle(1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("release_en", bus.mx_wb_en, 1'b1);
      check("release_mask", bus.mx_wb_mask, masks[k]);
      check("release_dest", bus.mx_wb_dest_reg, 5'(k + 1));
    end
    tick();
    check("release_done", bus.mx_wb_en, 1'b0);

    // Fill to DEPTH, then push and pop in the same cycle.
    for (int c = 0; c < DEPTH; c++) begin
      push_random(1'b1, 1'b1);
      tick();
    end
    check("full_count", bus.mx_queue_count, DEPTH);
    push_random(1'b1, 1'b0);
    tick();
    check("full_pushpop_count", bus.mx_queue_count, DEPTH);
    check("full_pushpop_en", bus.mx_wb_en, 1'b1);
    idle(1'b0);
    for (int c = 0; c < DEPTH + 1; c++) tick();
    check("full_drained", bus.mx_queue_count, 0);

    // Reset with 3 queued entries.
    for (int c = 0; c < 3; c++) begin
      push_random(1'b1, 1'b1);
      tick();
    end
    idle(1'b1);
    reset = 1'b1;
    tick();
    check("rst_count", bus.mx_queue_count, 0);
    check("rst_en", bus.mx_wb_en, 1'b0);
    check("rst_value", bus.mx_wb_value, '0);
    check("rst_dest", bus.mx_wb_dest_reg, 5'd0);
    reset = 1'b0;
    idle(1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_no_stale_write", bus.mx_wb_en, 1'b0);
    end

    // has_dest=0 interleaved with real results.
    for (int c = 0; c < 6; c++) begin
      push_random(1'((c % 2) == 0), 1'b1);
      tick();
    end
    check("hasdest_count", bus.mx_queue_count, 3);
    idle(1'b0);
    for (int c = 0; c < 4; c++) tick();

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      sx = ($urandom_range(0, 2) == 0);
      v  = ($urandom_range(0, 9) < 6);
      if (exp_q.size() == DEPTH && sx) v = 1'b0;
      if (v) push_random(1'($urandom_range(0, 4) != 0), sx);
      else   idle(sx);
      tick();
    end
    idle(1'b0);
    for (int c = 0; c < DEPTH + 2; c++) tick();
    check("final_empty", bus.mx_queue_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
